// File: rtl/sequence_generator_fsm.sv
// Serial pattern transmitter: shifts a captured parallel pattern out MSB-first on w,
// optionally repeating it after a programmable idle gap, with board-level status on HEX0/LEDR.
module sequence_generator_fsm #(
   parameter int PATTERN_LEN = 4,
   parameter int GAP_CYCLES  = 1
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic [PATTERN_LEN-1:0] pattern,
   input  logic                   repeat_en,
   output logic                   w,
   output logic                   valid,
   output logic                   busy,
   output logic                   done,
   output logic [3:0]             currstate,
   output logic [6:0]             HEX0,
   output logic [9:0]             LEDR
);

   typedef enum logic [3:0] {
      ST_IDLE = 4'd0,
      ST_SEND = 4'd1,
      ST_GAP  = 4'd2,
      ST_DONE = 4'd3
   } state_t;

   localparam logic [3:0] BIT_LOAD = 4'(PATTERN_LEN - 1);
   localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

   // Active-low seven-segment decode, segment order {g,f,e,d,c,b,a}.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
      logic [6:0] seg;
      case (value)
         4'h0:    seg = 7'b1000000;
         4'h1:    seg = 7'b1111001;
         4'h2:    seg = 7'b0100100;
         4'h3:    seg = 7'b0110000;
         4'h4:    seg = 7'b0011001;
         4'h5:    seg = 7'b0010010;
         4'h6:    seg = 7'b0000010;
         4'h7:    seg = 7'b1111000;
         4'h8:    seg = 7'b0000000;
         4'h9:    seg = 7'b0010000;
         4'hA:    seg = 7'b0001000;
         4'hB:    seg = 7'b0000011;
         4'hC:    seg = 7'b1000110;
         4'hD:    seg = 7'b0100001;
         4'hE:    seg = 7'b0000110;
         4'hF:    seg = 7'b0001110;
         default: seg = 7'b1111111;
      endcase
      return seg;
   endfunction

   state_t                 state_r, state_s;
   logic [PATTERN_LEN-1:0] shift_r, shift_s;
   logic [PATTERN_LEN-1:0] hold_r, hold_s;
   logic [3:0]             bit_cnt_r, bit_cnt_s;
   logic [3:0]             gap_cnt_r, gap_cnt_s;
   logic                   w_r, w_s;
   logic                   valid_r, valid_s;
   logic                   busy_r, busy_s;
   logic                   done_r, done_s;
   logic [6:0]             hex_r;

   // Next-state, datapath and next-output decode.
   always_comb begin
      state_s   = state_r;
      shift_s   = shift_r;
      hold_s    = hold_r;
      bit_cnt_s = bit_cnt_r;
      gap_cnt_s = gap_cnt_r;

      case (state_r)
         ST_IDLE: begin
            if (start) begin
               hold_s    = pattern;
               shift_s   = pattern;
               bit_cnt_s = BIT_LOAD;
               state_s   = ST_SEND;
            end else begin
               state_s   = ST_IDLE;
            end
         end
         ST_SEND: begin
            shift_s = shift_r << 1'b1;
            if (bit_cnt_r == 4'd0) begin
               // Last bit is on the wire: repeat_en decides what follows it.
               if (repeat_en && (GAP_CYCLES > 0)) begin
                  gap_cnt_s = GAP_LOAD;
                  state_s   = ST_GAP;
               end else if (repeat_en) begin
                  shift_s   = hold_r;
                  bit_cnt_s = BIT_LOAD;
                  state_s   = ST_SEND;
               end else begin
                  state_s   = ST_DONE;
               end
            end else begin
               bit_cnt_s = bit_cnt_r - 4'd1;
            end
         end
         ST_GAP: begin
            if (gap_cnt_r == 4'd0) begin
               shift_s   = hold_r;
               bit_cnt_s = BIT_LOAD;
               state_s   = ST_SEND;
            end else begin
               gap_cnt_s = gap_cnt_r - 4'd1;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase

      // Outputs are decoded from the next state so they land in flops aligned with it.
      if (state_s == ST_SEND) begin
         w_s     = shift_s[PATTERN_LEN-1];
         valid_s = 1'b1;
      end else begin
         w_s     = 1'b0;
         valid_s = 1'b0;
      end
      busy_s = (state_s != ST_IDLE);
      done_s = (state_s == ST_DONE);
   end

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         shift_r   <= {PATTERN_LEN{1'b0}};
         hold_r    <= {PATTERN_LEN{1'b0}};
         bit_cnt_r <= 4'd0;
         gap_cnt_r <= 4'd0;
         w_r       <= 1'b0;
         valid_r   <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         hex_r     <= hex_to_seg(4'd0);
      end else begin
         state_r   <= state_s;
         shift_r   <= shift_s;
         hold_r    <= hold_s;
         bit_cnt_r <= bit_cnt_s;
         gap_cnt_r <= gap_cnt_s;
         w_r       <= w_s;
         valid_r   <= valid_s;
         busy_r    <= busy_s;
         done_r    <= done_s;
         hex_r     <= hex_to_seg(state_s);
      end
   end

   assign w         = w_r;
   assign valid     = valid_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign currstate = state_r;
   assign HEX0      = hex_r;
   assign LEDR      = {6'b000000, done_r, busy_r, valid_r, w_r};

endmodule

// File: tb/tb_sequence_generator_fsm.sv
// Randomized bench for sequence_generator_fsm: two instances (gap of 1 and gapless) are checked
// every cycle against a queue-based model of the expected output stream.
module tb_sequence_generator_fsm;

   localparam int LEN = 4;

   typedef struct packed {
      logic       w;
      logic       v;
      logic [3:0] st;
   } item_t;

   logic           clock = 1'b0;
   logic           rst_i, start_i, rep_i;
   logic [LEN-1:0] pat_i;

   logic       w_a, v_a, b_a, d_a, w_b, v_b, b_b, d_b;
   logic [3:0] cs_a, cs_b;
   logic [6:0] hx_a, hx_b;
   logic [9:0] ld_a, ld_b;

   int tests_run    = 0;
   int tests_failed = 0;

   item_t          mq   [2][$];
   item_t          cur  [2];
   logic [LEN-1:0] hold [2];

   always #5 clock = ~clock;

   sequence_generator_fsm #(.PATTERN_LEN(LEN), .GAP_CYCLES(1)) dut_gap1 (
      .clock(clock), .reset(rst_i), .start(start_i), .pattern(pat_i), .repeat_en(rep_i),
      .w(w_a), .valid(v_a), .busy(b_a), .done(d_a), .currstate(cs_a), .HEX0(hx_a), .LEDR(ld_a));

   sequence_generator_fsm #(.PATTERN_LEN(LEN), .GAP_CYCLES(0)) dut_gap0 (
      .clock(clock), .reset(rst_i), .start(start_i), .pattern(pat_i), .repeat_en(rep_i),
      .w(w_b), .valid(v_b), .busy(b_b), .done(d_b), .currstate(cs_b), .HEX0(hx_b), .LEDR(ld_b));

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [6:0] seg_of(input logic [3:0] st);
      case (st)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         default: return 7'b1111111;
      endcase
   endfunction

   task automatic push_pattern(input int m);
      for (int i = LEN - 1; i >= 0; i--) mq[m].push_back({hold[m][i], 1'b1, 4'd1});
   endtask

   // Advance the expected stream by one clock edge using the inputs seen at that edge.
   task automatic model_step();
      for (int m = 0; m < 2; m++) begin
         int gap;
         gap = (m == 0) ? 1 : 0;
         if (rst_i) begin
            mq[m].delete();
            cur[m] = {1'b0, 1'b0, 4'd0};
         end else if (mq[m].size() != 0) begin
            cur[m] = mq[m].pop_front();
         end else if (cur[m].st == 4'd0) begin
            if (start_i) begin
               hold[m] = pat_i;
               push_pattern(m);
               cur[m] = mq[m].pop_front();
            end
         end else if (cur[m].st == 4'd1 && rep_i) begin
            for (int g = 0; g < gap; g++) mq[m].push_back({1'b0, 1'b0, 4'd2});
            push_pattern(m);
            cur[m] = mq[m].pop_front();
         end else if (cur[m].st == 4'd1) begin
            cur[m] = {1'b0, 1'b0, 4'd3};
         end else begin
            cur[m] = {1'b0, 1'b0, 4'd0};
         end
      end
   endtask

   task automatic check_dut(input string nm, input int m, input logic w, input logic v,
                            input logic b, input logic d, input logic [3:0] cs,
                            input logic [6:0] hx, input logic [9:0] ld);
      logic eb, ed;
      eb = (cur[m].st != 4'd0);
      ed = (cur[m].st == 4'd3);
      check_eq({nm, "_w"},     32'(w),  32'(cur[m].w));
      check_eq({nm, "_valid"}, 32'(v),  32'(cur[m].v));
      check_eq({nm, "_busy"},  32'(b),  32'(eb));
      check_eq({nm, "_done"},  32'(d),  32'(ed));
      check_eq({nm, "_state"}, 32'(cs), 32'(cur[m].st));
      check_eq({nm, "_hex"},   32'(hx), 32'(seg_of(cur[m].st)));
      check_eq({nm, "_ledr"},  32'(ld), 32'({6'b000000, ed, eb, cur[m].v, cur[m].w}));
   endtask

   task automatic cycle(input logic r, input logic s, input logic [LEN-1:0] p, input logic rep);
      rst_i   = r;
      start_i = s;
      pat_i   = p;
      rep_i   = rep;
      @(posedge clock);
      model_step();
      @(negedge clock);
      check_dut("gap1", 0, w_a, v_a, b_a, d_a, cs_a, hx_a, ld_a);
      check_dut("gap0", 1, w_b, v_b, b_b, d_b, cs_b, hx_b, ld_b);
   endtask

   initial begin
      logic rep_hold;
      for (int m = 0; m < 2; m++) begin
         cur[m]  = {1'b0, 1'b0, 4'd0};
         hold[m] = 4'b0000;
      end
      cycle(1'b1, 1'b0, 4'b0000, 1'b0);
      cycle(1'b1, 1'b0, 4'b0000, 1'b0);

      // Single pattern, no repeat.
      cycle(1'b0, 1'b1, 4'b1101, 1'b0);
      repeat (7) cycle(1'b0, 1'b0, 4'($urandom), 1'b0);

      // Repeat, then drop repeat_en during the second pattern.
      cycle(1'b0, 1'b1, 4'b1011, 1'b1);
      repeat (6) cycle(1'b0, 1'b0, 4'($urandom), 1'b1);
      repeat (10) cycle(1'b0, 1'b0, 4'($urandom), 1'b0);

      // Three gapless patterns on the GAP_CYCLES=0 instance.
      cycle(1'b0, 1'b1, 4'b1001, 1'b1);
      repeat (10) cycle(1'b0, 1'b0, 4'($urandom), 1'b1);
      repeat (12) cycle(1'b0, 1'b0, 4'($urandom), 1'b0);

      // Second start and a pattern change during a transfer are ignored.
      cycle(1'b0, 1'b1, 4'b1101, 1'b0);
      cycle(1'b0, 1'b0, 4'b1101, 1'b0);
      cycle(1'b0, 1'b1, 4'b0000, 1'b0);
      repeat (8) cycle(1'b0, 1'b0, 4'b0000, 1'b0);

      // Reset in the middle of a send, then a fresh transfer.
      cycle(1'b0, 1'b1, 4'b1111, 1'b1);
      cycle(1'b0, 1'b0, 4'b0000, 1'b1);
      cycle(1'b1, 1'b0, 4'b0000, 1'b1);
      cycle(1'b0, 1'b1, 4'b0110, 1'b0);
      repeat (7) cycle(1'b0, 1'b0, 4'b0000, 1'b0);

      // Reset and start on the same edge.
      cycle(1'b1, 1'b1, 4'b1111, 1'b1);
      repeat (2) cycle(1'b0, 1'b0, 4'b0000, 1'b0);

      rep_hold = 1'b0;
      repeat (3000) begin
         if ($urandom_range(0, 15) == 0) rep_hold = ~rep_hold;
         cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) == 0), 4'($urandom), rep_hold);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
